// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Blink-rate prescaler plus RUN/PAUSE controller that walks the five LED
// patterns and their steps for the downstream LED decode logic.
module led_pattern_sequencer #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BLINK_FREQ = 2,
  parameter int REPEATS    = 2
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       pause_req,
  input  logic       next_req,
  output logic [2:0] pattern_state,
  output logic [3:0] step,
  output logic       step_tick,
  output logic       pattern_done,
  output logic       paused
);

  localparam int DIV   = CLK_FREQ / BLINK_FREQ;
  localparam int CNT_W = $clog2(DIV);
  localparam int REP_W = $clog2(REPEATS + 1);

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [REP_W-1:0] rep;
  logic             tick_i;
  logic             rep_last;
  logic [3:0]       last_step;
  logic [2:0]       next_pattern;

  assign tick_i       = (cnt == CNT_W'(DIV - 1));
  assign rep_last     = (rep == REP_W'(REPEATS - 1));
  assign next_pattern = (pattern_state == 3'd4) ? 3'd0 : pattern_state + 3'd1;

  // Last valid step index of the pattern currently being shown
  always_comb begin
    last_step = 4'd1;
    case (pattern_state)
      3'd0:    last_step = 4'd15;
      3'd1:    last_step = 4'd5;
      3'd2:    last_step = 4'd7;
      default: last_step = 4'd1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: pause_req toggles, next_req never touches the state
  always_comb begin
    state_next = state;
    if (pause_req) begin
      state_next = (state == RUN) ? PAUSE : RUN;
    end
  end

  // FSM output: paused is a direct decode of the state flop
  always_comb begin
    paused = (state == PAUSE);
  end

  // Prescaler, step/repeat/pattern walk and the one-cycle status pulses;
  // a skip request overrides any coincident tick and realigns the prescaler
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      rep           <= '0;
      step          <= 4'd0;
      pattern_state <= 3'd0;
      step_tick     <= 1'b0;
      pattern_done  <= 1'b0;
    end else begin
      step_tick    <= 1'b0;
      pattern_done <= 1'b0;
      if (next_req) begin
        cnt           <= '0;
        rep           <= '0;
        step          <= 4'd0;
        pattern_state <= next_pattern;
      end else begin
        cnt <= tick_i ? '0 : cnt + CNT_W'(1);
        if (tick_i && (state == RUN)) begin
          step_tick <= 1'b1;
          if (step != last_step) begin
            step <= step + 4'd1;
          end else begin
            step <= 4'd0;
            if (!rep_last) begin
              rep <= rep + REP_W'(1);
            end else begin
              rep           <= '0;
              pattern_state <= next_pattern;
              pattern_done  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
// Scoreboard bench: the driver advances a position-based reference model each
// cycle and queues expected tick/done pulses; a monitor compares them and the
// model's current pattern/step/paused against the DUT after every edge.
module tb_led_pattern_sequencer;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BLINK_FREQ = 2_000_000;
  localparam int REPEATS    = 1;
  localparam int DIV        = CLK_FREQ / BLINK_FREQ;

  logic       clk_50mhz = 1'b0;
  logic       rst       = 1'b1;
  logic       pause_req = 1'b0;
  logic       next_req  = 1'b0;
  logic [2:0] pattern_state;
  logic [3:0] step;
  logic       step_tick;
  logic       pattern_done;
  logic       paused;

  led_pattern_sequencer #(
    .CLK_FREQ  (CLK_FREQ),
    .BLINK_FREQ(BLINK_FREQ),
    .REPEATS   (REPEATS)
  ) dut (
    .clk_50mhz    (clk_50mhz),
    .rst          (rst),
    .pause_req    (pause_req),
    .next_req     (next_req),
    .pattern_state(pattern_state),
    .step         (step),
    .step_tick    (step_tick),
    .pattern_done (pattern_done),
    .paused       (paused)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  typedef struct {
    int cycle;
    int pat;
    int stp;
    int done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int len_tab[5] = '{16, 6, 8, 2, 2};

  int m_cnt      = 0;
  int m_pat      = 0;
  int m_pos      = 0;
  int m_paused   = 0;
  bit model_live = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic int curStep();
    return m_pos % len_tab[m_pat];
  endfunction

  task automatic modelReset();
    m_cnt    = 0;
    m_pat    = 0;
    m_pos    = 0;
    m_paused = 0;
  endtask

  // Called at a falling edge: drive inputs for the next rising edge and
  // advance the reference model to the value expected after that edge
  task automatic applyStimulus(input bit pr, input bit nr);
    bit tick;
    int done;
    pause_req = pr;
    next_req  = nr;
    tick      = (m_cnt == DIV - 1);
    if (nr) begin
      m_pat = (m_pat + 1) % 5;
      m_pos = 0;
      m_cnt = 0;
    end else begin
      m_cnt = tick ? 0 : m_cnt + 1;
      if (tick && (m_paused == 0)) begin
        done  = 0;
        m_pos = m_pos + 1;
        if (m_pos == len_tab[m_pat] * REPEATS) begin
          m_pos = 0;
          m_pat = (m_pat + 1) % 5;
          done  = 1;
        end
        exp_q.push_back('{cyc + 1, m_pat, curStep(), done});
      end
    end
    if (pr) m_paused = 1 - m_paused;
    @(negedge clk_50mhz);
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pattern_state"}, int'(pattern_state), 0);
    checkOutput({tag, "_step"}, int'(step), 0);
    checkOutput({tag, "_step_tick"}, int'(step_tick), 0);
    checkOutput({tag, "_pattern_done"}, int'(pattern_done), 0);
    checkOutput({tag, "_paused"}, int'(paused), 0);
  endtask

  // Asynchronous reset in the middle of a cycle, held across one rising edge
  task automatic applyReset();
    @(posedge clk_50mhz);
    #2;
    pause_req = 1'b0;
    next_req  = 1'b0;
    rst       = 1'b1;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    rst = 1'b0;
  endtask

  // Monitor: pops expected pulses when due and checks the model state each cycle
  always @(posedge clk_50mhz) begin
    cyc++;
    #1;
    if (!rst && model_live) begin
      checkOutput("pattern_state", int'(pattern_state), m_pat);
      checkOutput("step", int'(step), curStep());
      checkOutput("paused", int'(paused), m_paused);
      if (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
        mon_e = exp_q.pop_front();
        checkOutput("step_tick", int'(step_tick), 1);
        checkOutput("pattern_done", int'(pattern_done), mon_e.done);
        checkOutput("tick_pattern", int'(pattern_state), mon_e.pat);
        checkOutput("tick_step", int'(step), mon_e.stp);
      end else begin
        checkOutput("no_step_tick", int'(step_tick), 0);
        checkOutput("no_pattern_done", int'(pattern_done), 0);
      end
    end
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk_50mhz);
    checkAllZero("reset_state");
    rst = 1'b0;
    modelReset();
    model_live = 1'b1;

    $display("[TB] free run from reset");
    runIdle(400);
    runIdle(900);

    $display("[TB] pause at pattern 2 step 3");
    guard = 0;
    while (!(m_pat == 2 && curStep() == 3 && m_paused == 0) && guard < 3000) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    checkOutput("reach_p2_s3", m_pat * 16 + curStep(), 2 * 16 + 3);
    applyStimulus(1'b1, 1'b0);
    runIdle(200);
    applyStimulus(1'b1, 1'b0);
    runIdle(30);

    $display("[TB] skip coincident with tick at pattern 4");
    guard = 0;
    while (!(m_pat == 4 && m_cnt == DIV - 1 && m_paused == 0) && guard < 3000) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    checkOutput("reach_p4_tick", m_pat * 100 + m_cnt, 4 * 100 + DIV - 1);
    applyStimulus(1'b0, 1'b1);
    runIdle(30);

    $display("[TB] skip while paused at pattern 1");
    applyStimulus(1'b1, 1'b0);
    guard = 0;
    while (m_pat != 1 && guard < 6) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    applyStimulus(1'b0, 1'b1);
    runIdle(5);
    applyStimulus(1'b1, 1'b0);
    runIdle(50);

    $display("[TB] simultaneous pause and skip, pause with tick");
    applyStimulus(1'b1, 1'b1);
    runIdle(40);
    applyStimulus(1'b1, 1'b1);
    guard = 0;
    while (m_cnt != DIV - 1 && guard < 100) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    applyStimulus(1'b1, 1'b0);
    runIdle(60);
    applyStimulus(1'b1, 1'b0);
    runIdle(30);

    $display("[TB] reset during pause at pattern 3");
    guard = 0;
    while (m_pat != 3 && guard < 6) begin
      applyStimulus(1'b0, 1'b1);
      guard++;
    end
    runIdle(30);
    applyStimulus(1'b1, 1'b0);
    runIdle(40);
    applyReset();
    runIdle(120);

    $display("[TB] randomized pulses");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 89) == 0));
    end
    runIdle(3);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
